clk_freq_meter: RTL and testbench
=================================

// Module: clk_freq_meter
// PURPOSE
//  Measures the frequency of a low-rate clock, e.g. the rPLL divided output (50 kHz from 27 MHz), against system clk.
//  Gated edge counter: meas_in is synchronised into clk, rising edges are counted over a fixed window,
//  and the result is reported with a range check. Drives the LED/UART status path as a PLL-output sanity monitor.
// PARAMETERS
//  GATE_CYCLES  27_000_000  window length in clk cycles (1 s at 27 MHz); >= 2
//  CNT_W        32          width of freq_cnt / period_cnt
//  EXP_MIN      49_900      lowest freq_cnt for in_range=1
//  EXP_MAX      50_100      highest freq_cnt for in_range=1
//  SYNC_STAGES  2           synchroniser flops on meas_in; >= 2
// PORTS
//  clk         in   1      system clock (27 MHz)
//  rst_n       in   1      synchronous reset, active-low
//  en          in   1      1 = measure continuously; 0 = idle
//  meas_in     in   1      clock under test, asynchronous to clk
//  freq_cnt    out  CNT_W  edges counted in last completed window
//  freq_valid  out  1      one-cycle pulse: freq_cnt/in_range/no_signal updated this cycle
//  in_range    out  1      EXP_MIN <= freq_cnt <= EXP_MAX and no saturation
//  no_signal   out  1      last window counted zero edges
//  period_cnt  out  CNT_W  clk cycles between last two meas_in rising edges (0 when feature off)
//  period_valid out 1      one-cycle pulse on period_cnt update (0 when feature off)
// BEHAVIOUR
//  - Reset (rst_n=0 at clk edge): all outputs 0, FSM=IDLE, gate timer/edge counter 0, synchroniser cleared.
//  - Edge pulse: SYNC_STAGES flops + 1 delay flop; pulse = sync & ~dly; 1 clk wide, SYNC_STAGES+1 cycles after input edge.
//  - Valid only for meas_in high >= 2 clk and low >= 2 clk; faster inputs alias, result unspecified.
//  - FSM IDLE: timer/counter held 0; en=1 -> GATE next cycle.
//  - FSM GATE: timer 0..GATE_CYCLES-1, edge counter += edge pulse. On timer==GATE_CYCLES-1:
//    next cycle freq_cnt <= count (incl. edge on final cycle), freq_valid=1, timer wraps to 0,
//    edge counter restarts from 0 (or 1 if edge pulse in that cycle). Windows contiguous, no edge lost or double-counted.
//  - First freq_valid exactly GATE_CYCLES+1 cycles after en sampled 1; then every GATE_CYCLES cycles.
//  - en=0 in GATE: abort -> IDLE next cycle, no freq_valid, outputs hold last values. en=1 on wrap cycle still reports.
//  - Saturation: edge counter stops at 2^CNT_W-1, sticky sat flag for that window; report gives max value, in_range=0.
//  - in_range, no_signal registered with freq_cnt; change only on freq_valid.
//  - rst_n=0 mid-window: window discarded, outputs 0 next cycle.
// CONFIGURATION
//  FREQ_METER_PERIOD_EN defined: period counter increments each clk in GATE, saturates at 2^CNT_W-1;
//    on edge pulse: if a prior edge seen in this enable session, period_cnt <= counter+1 and period_valid=1;
//    counter cleared either way. First edge after en or IDLE only arms, no pulse.
//  Not defined: no period logic; period_cnt=0, period_valid=0 permanently; ports kept.
// STRUCTURE
//  freq_meter_pkg: FSM state enum {ST_IDLE, ST_GATE}, default localparams (27 MHz, 50 kHz window bounds).
//  Sub-module sync_edge_det (SYNC_STAGES param): synchroniser + rising-edge pulse; reusable for buttons.
//  Top: FSM, gate timer, edge counter, range compare, optional period logic.
// TESTING (bench: GATE_CYCLES=1000, EXP_MIN=49, EXP_MAX=51, CNT_W=16 unless stated)
//  1. meas_in period 20 clk (10/10), en=1 -> freq_valid at cycle 1001 then every 1000, freq_cnt=50, in_range=1.
//  2. meas_in stuck 0 -> freq_cnt=0, no_signal=1, in_range=0 on each freq_valid.
//  3. CNT_W=4, meas_in period 4 clk -> freq_cnt=15 (saturated), in_range=0.
//  4. en=0 at window cycle 500 -> no freq_valid, freq_cnt holds 50; en=1 again -> next valid 1001 cycles later, 50.
//  5. rst_n=0 at window cycle 300 -> all outputs 0 next cycle; after release + en, first report freq_cnt=50.
//  6. FREQ_METER_PERIOD_EN, period 20 -> no pulse on first edge, then period_valid every 20 clk, period_cnt=20.

Source files
------------

// File: rtl/freq_meter_pkg.sv
// Shared types and default parameter values for the clock frequency meter.
// Defaults target a 50 kHz clock under test measured against a 27 MHz system clock.
// Contents: FSM state enum, default window length, counter width, range bounds, synchroniser depth.
package freq_meter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_GATE = 1'b1
  } state_t;

  localparam int DEF_GATE_CYCLES = 27_000_000;
  localparam int DEF_CNT_W       = 32;
  localparam int DEF_EXP_MIN     = 49_900;
  localparam int DEF_EXP_MAX     = 50_100;
  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/sync_edge_det.sv
// Synchroniser plus rising-edge detector for an asynchronous level input.
// Latency: rise is asserted SYNC_STAGES cycles after din is first sampled high; one cycle wide.
// No backpressure: a pulse is produced for every detected edge.
// Ports: clk, rst_n (sync, active-low), din (async level), rise (1-cycle pulse).
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   dly_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q <= '0;
      dly_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      dly_q  <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter measuring a slow clock against clk, with range check and optional period measurement.
// Latency: first freq_valid GATE_CYCLES+1 cycles after en is sampled high, then every GATE_CYCLES cycles.
// No backpressure: results are single-cycle pulses; freq_cnt/in_range/no_signal hold until the next report.
// Ports: clk, rst_n, en, meas_in -> freq_cnt, freq_valid, in_range, no_signal, period_cnt, period_valid.
// Optional feature macro: FREQ_METER_PERIOD_EN (period counter between successive meas_in rising edges).
module clk_freq_meter
  import freq_meter_pkg::*;
#(
  parameter int GATE_CYCLES = DEF_GATE_CYCLES,
  parameter int CNT_W       = DEF_CNT_W,
  parameter int EXP_MIN     = DEF_EXP_MIN,
  parameter int EXP_MAX     = DEF_EXP_MAX,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             meas_in,
  output logic [CNT_W-1:0] freq_cnt,
  output logic             freq_valid,
  output logic             in_range,
  output logic             no_signal,
  output logic [CNT_W-1:0] period_cnt,
  output logic             period_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam int               TMR_W    = $clog2(GATE_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(GATE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [TMR_W-1:0] timer_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             sat_q;
  logic             edge_pulse;

  logic             gate_run;
  logic             win_end;
  logic [CNT_W-1:0] cnt_final;
  logic             sat_final;
  logic             range_ok;

  sync_edge_det #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (meas_in),
    .rise (edge_pulse)
  );

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: en alone decides between measuring and idling
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (en)  state_d = ST_GATE;
      ST_GATE: if (!en) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output/control decode. cnt_final includes an edge arriving on the current
  // cycle so the window-closing cycle is never lost.
  always_comb begin
    gate_run  = (state_q == ST_GATE) && en;
    win_end   = gate_run && (timer_q == TMR_LAST);
    cnt_final = edge_cnt_q;
    sat_final = sat_q;
    if (edge_pulse) begin
      if (edge_cnt_q == CNT_MAX) sat_final = 1'b1;
      else                       cnt_final = edge_cnt_q + CNT_W'(1);
    end
    range_ok = !sat_final &&
               (64'(cnt_final) >= 64'(EXP_MIN)) &&
               (64'(cnt_final) <= 64'(EXP_MAX));
  end

  // Gate timer, edge counter and result registers. On the closing cycle the
  // counter restarts with that cycle's edge so consecutive windows tile exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q    <= '0;
      edge_cnt_q <= '0;
      sat_q      <= 1'b0;
      freq_cnt   <= '0;
      freq_valid <= 1'b0;
      in_range   <= 1'b0;
      no_signal  <= 1'b0;
    end else begin
      freq_valid <= 1'b0;
      if (win_end) begin
        timer_q    <= '0;
        edge_cnt_q <= CNT_W'(edge_pulse);
        sat_q      <= 1'b0;
        freq_cnt   <= cnt_final;
        freq_valid <= 1'b1;
        in_range   <= range_ok;
        no_signal  <= (cnt_final == '0);
      end else if (gate_run) begin
        timer_q    <= timer_q + TMR_W'(1);
        edge_cnt_q <= cnt_final;
        sat_q      <= sat_final;
      end else begin
        // Idle or aborting: partial window is discarded, results hold.
        timer_q    <= '0;
        edge_cnt_q <= '0;
        sat_q      <= 1'b0;
      end
    end
  end

`ifdef FREQ_METER_PERIOD_EN
  logic [CNT_W-1:0] per_ctr_q;
  logic             armed_q;

  // Period counter: the first edge of an enable session only arms it,
  // later edges report the cycles since the previous edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_ctr_q    <= '0;
      armed_q      <= 1'b0;
      period_cnt   <= '0;
      period_valid <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (state_q == ST_GATE) begin
        if (edge_pulse) begin
          per_ctr_q <= '0;
          armed_q   <= 1'b1;
          if (armed_q) begin
            period_cnt   <= (per_ctr_q == CNT_MAX) ? CNT_MAX : per_ctr_q + CNT_W'(1);
            period_valid <= 1'b1;
          end
        end else if (per_ctr_q != CNT_MAX) begin
          per_ctr_q <= per_ctr_q + CNT_W'(1);
        end
      end else begin
        per_ctr_q <= '0;
        armed_q   <= 1'b0;
      end
    end
  end
`else
  assign period_cnt   = '0;
  assign period_valid = 1'b0;
`endif

endmodule

// File: tb/tb_clk_freq_meter.sv
module tb_clk_freq_meter;

  localparam int GATE = 1000;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        meas_in;
  logic [15:0] freq_cnt;
  logic        freq_valid;
  logic        in_range;
  logic        no_signal;
  logic [15:0] period_cnt;
  logic        period_valid;

  logic        en_sat;
  logic        meas_sat;
  logic [3:0]  s_freq_cnt;
  logic        s_freq_valid;
  logic        s_in_range;
  logic        s_no_signal;
  logic [3:0]  s_period_cnt;
  logic        s_period_valid;

  clk_freq_meter #(
    .GATE_CYCLES(GATE), .CNT_W(16), .EXP_MIN(49), .EXP_MAX(51), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .meas_in(meas_in),
    .freq_cnt(freq_cnt), .freq_valid(freq_valid), .in_range(in_range),
    .no_signal(no_signal), .period_cnt(period_cnt), .period_valid(period_valid)
  );

  // Narrow counter instance: bounds include 15 so only saturation can clear in_range.
  clk_freq_meter #(
    .GATE_CYCLES(GATE), .CNT_W(4), .EXP_MIN(10), .EXP_MAX(15), .SYNC_STAGES(2)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_sat), .meas_in(meas_sat),
    .freq_cnt(s_freq_cnt), .freq_valid(s_freq_valid), .in_range(s_in_range),
    .no_signal(s_no_signal), .period_cnt(s_period_cnt), .period_valid(s_period_valid)
  );

  typedef struct {
    int n;      // rising edges per 1000-cycle frame
    int step;   // spacing of those edges in clk cycles
    int freq;   // expected freq_cnt
    int rng;    // expected in_range
    int nos;    // expected no_signal
  } vec_t;

  typedef struct {
    int freq;
    int rng;
    int nos;
    int gap;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  exp_t mon_e;

  int n_vec  = 0;
  int n_mis  = 0;
  int cyc    = 0;
  int ref_cyc = 0;
  int gen_n  = 0;
  int gen_step = 20;
  int pos    = 0;
  int sat_ph = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Stimulus generator: a 1000-cycle periodic pattern with exactly gen_n rising
  // edges, so every contiguous window counts gen_n regardless of phase.
  initial begin
    meas_in = 1'b0;
    forever begin
      @(negedge clk);
      pos = (pos == GATE - 1) ? 0 : pos + 1;
      meas_in = (gen_n != 0) && (pos < gen_n * gen_step) && ((pos % gen_step) < (gen_step / 2));
    end
  end

  // Period-4 clock for the saturation instance (250 edges per window).
  initial begin
    meas_sat = 1'b0;
    forever begin
      @(negedge clk);
      sat_ph = (sat_ph == 1) ? 0 : sat_ph + 1;
      if (sat_ph == 0) meas_sat = ~meas_sat;
    end
  end

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_mis++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  // Scoreboard consumer: every freq_valid on the main instance must match the
  // oldest expectation, including its distance from the reference cycle.
  initial forever begin
    @(negedge clk);
    if (rst_n && freq_valid) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_mis++;
        $display("FAIL unexpected_valid: freq_valid with no expectation, freq_cnt=%0d (cycle %0d)", freq_cnt, cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("freq_cnt",  freq_cnt,        mon_e.freq);
        chk("in_range",  in_range,        mon_e.rng);
        chk("no_signal", no_signal,       mon_e.nos);
        chk("valid_gap", cyc - ref_cyc,   mon_e.gap);
      end
      ref_cyc = cyc;
    end
  end

  task automatic wait_drain(input int limit);
    int t = 0;
    while (sb.size() > 0 && t < limit) begin
      @(negedge clk);
      t++;
    end
    n_vec++;
    if (sb.size() > 0) begin
      n_mis++;
      $display("FAIL drain_timeout: %0d reports outstanding, expected 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic set_pattern(input int n, input int step);
    gen_n    = n;
    gen_step = step;
    repeat (10) @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v);
    set_pattern(v.n, v.step);
    sb.push_back('{v.freq, v.rng, v.nos, GATE + 1});
    sb.push_back('{v.freq, v.rng, v.nos, GATE});
    ref_cyc = cyc;
    en = 1'b1;
    wait_drain(2 * GATE + 300);
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic period_check();
    int t;
    int seen;
    en = 1'b1;
`ifdef FREQ_METER_PERIOD_EN
    t = 0;
    while (!period_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("period_first_seen", period_valid, 1);
    chk("period_cnt_first",  period_cnt,   20);
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!period_valid && t < 100);
    chk("period_gap",        t,            20);
    chk("period_cnt_second", period_cnt,   20);
`else
    seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (period_valid) seen++;
    end
    chk("period_valid_off", seen,       0);
    chk("period_cnt_off",   period_cnt, 0);
`endif
    en = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int t;
    vecs[0] = '{50,  20, 50,  1, 0};
    vecs[1] = '{0,   20, 0,   0, 1};
    vecs[2] = '{49,  20, 49,  1, 0};
    vecs[3] = '{51,  19, 51,  1, 0};
    vecs[4] = '{48,  20, 48,  0, 0};
    vecs[5] = '{52,  19, 52,  0, 0};
    vecs[6] = '{100, 10, 100, 0, 0};

    rst_n  = 1'b0;
    en     = 1'b0;
    en_sat = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_freq_cnt",   freq_cnt,     0);
    chk("rst_freq_valid", freq_valid,   0);
    chk("rst_in_range",   in_range,     0);
    chk("rst_no_signal",  no_signal,    0);
    chk("rst_period_cnt", period_cnt,   0);
    chk("rst_sat_cnt",    s_freq_cnt,   0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      run_vec(vecs[i]);
      if (i == 0) begin
        // Abort mid-window: no report, previous result holds.
        en = 1'b1;
        repeat (500) @(negedge clk);
        en = 1'b0;
        repeat (1200) @(negedge clk);
        chk("abort_hold_freq",  freq_cnt, 50);
        chk("abort_hold_range", in_range, 1);
        sb.push_back('{50, 1, 0, GATE + 1});
        ref_cyc = cyc;
        en = 1'b1;
        wait_drain(GATE + 300);
        en = 1'b0;
        repeat (5) @(negedge clk);
        period_check();
      end
    end

    // Reset mid-window discards the window and clears results.
    set_pattern(50, 20);
    en = 1'b1;
    repeat (300) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_freq_cnt",   freq_cnt,   0);
    chk("midrst_freq_valid", freq_valid, 0);
    chk("midrst_in_range",   in_range,   0);
    chk("midrst_no_signal",  no_signal,  0);
    en    = 1'b0;
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    sb.push_back('{50, 1, 0, GATE + 1});
    ref_cyc = cyc;
    en = 1'b1;
    wait_drain(GATE + 300);
    en = 1'b0;
    repeat (5) @(negedge clk);

    // Saturation on the 4-bit instance.
    en_sat = 1'b1;
    t = 0;
    while (!s_freq_valid && t < GATE + 100) begin
      @(negedge clk);
      t++;
    end
    chk("sat_latency",   t,           GATE + 1);
    chk("sat_freq_cnt",  s_freq_cnt,  15);
    chk("sat_in_range",  s_in_range,  0);
    chk("sat_no_signal", s_no_signal, 0);
    en_sat = 1'b0;
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
